// File: rtl/axis_pkt_framer.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_framer
// Description : Frames an unframed AXI-Stream beat stream (no tlast) into
//               packets of PKT_LEN beats. A short packet is closed early when
//               the input stays idle for TIMEOUT cycles (0 disables this).
//               A one-beat hold register sits in front of a registered output
//               stage. The hold lets the framer decide, when it hands a beat
//               on, whether that beat ends the packet.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               s_tdata/s_tvalid  - unframed input beat
//               s_tready          - input ready (combinational)
//               m_tdata/m_tvalid/m_tlast - framed output (registered)
//               m_tready          - downstream ready
//               timeout_flush     - 1-cycle pulse when a packet is closed by
//                                   timeout (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_framer #(
    parameter int DW      = 8,
    parameter int PKT_LEN = 4096,
    parameter int TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic          timeout_flush
);

    localparam int            c_BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int            c_IW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(PKT_LEN - 1);
    localparam logic [c_IW-1:0] c_IDLE_MAX  = c_IW'(TIMEOUT - 1);
    localparam logic          c_TO_EN     = (TIMEOUT != 0);

    // Hold register
    logic [DW-1:0]   r_hd;
    logic            r_hv;
    logic            r_hl;
    // Counters
    logic [c_BW-1:0] r_beat_cnt;
    logic [c_IW-1:0] r_idle_cnt;
    // Output stage
    logic [DW-1:0]   r_m_tdata;
    logic            r_m_tvalid;
    logic            r_m_tlast;
    logic            r_flush_pulse;

    logic w_out_free;
    logic w_s_ready;
    logic w_s_fire;
    logic w_at_last;
    logic w_idle_cond;
    logic w_flush;
    logic w_xfer;
    logic w_idle_inc;

    assign w_out_free  = ~r_m_tvalid | m_tready;
    assign w_s_ready   = ~rst & (~r_hv | w_out_free);
    assign w_s_fire    = s_tvalid & w_s_ready;
    assign w_at_last   = (r_beat_cnt == c_LAST_BEAT);

    // The held beat is a non-last beat with nothing behind it yet.
    assign w_idle_cond = r_hv & ~r_hl & ~s_tvalid;

    // A beat arriving in the same cycle wins over the timeout: it proves
    // the packet is still alive, so the held beat leaves as a normal beat.
    assign w_flush     = c_TO_EN & w_idle_cond & (r_idle_cnt == c_IDLE_MAX) & w_out_free;

    // The held beat moves on once its tlast value is known: it was the
    // position-last beat, a successor has arrived, or the timeout fired.
    assign w_xfer      = r_hv & w_out_free & (r_hl | w_s_fire | w_flush);

    assign w_idle_inc  = c_TO_EN & w_idle_cond & (r_idle_cnt != c_IDLE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hd          <= '0;
            r_hv          <= 1'b0;
            r_hl          <= 1'b0;
            r_beat_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_m_tdata     <= '0;
            r_m_tvalid    <= 1'b0;
            r_m_tlast     <= 1'b0;
            r_flush_pulse <= 1'b0;
        end else begin
            r_flush_pulse <= w_flush;

            // Output stage
            if (w_xfer) begin
                r_m_tdata  <= r_hd;
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= r_hl | w_flush;
            end else if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end

            // Hold register: a new beat may refill it in the same cycle the
            // old one leaves.
            if (w_s_fire) begin
                r_hd <= s_tdata;
                r_hv <= 1'b1;
                r_hl <= w_at_last;
            end else if (w_xfer) begin
                r_hv <= 1'b0;
                r_hl <= 1'b0;
            end

            // Beat position inside the current packet. A flush never
            // coincides with an accepted beat (it needs s_tvalid low).
            if (w_s_fire) begin
                r_beat_cnt <= w_at_last ? '0 : r_beat_cnt + c_BW'(1);
            end else if (w_flush) begin
                r_beat_cnt <= '0;
            end

            // Idle counter saturates, so a flush blocked by backpressure
            // stays armed until the output frees up.
            if (w_s_fire | w_xfer) begin
                r_idle_cnt <= '0;
            end else if (w_idle_inc) begin
                r_idle_cnt <= r_idle_cnt + c_IW'(1);
            end
        end
    end

    assign s_tready      = w_s_ready;
    assign m_tdata       = r_m_tdata;
    assign m_tvalid      = r_m_tvalid;
    assign m_tlast       = r_m_tlast;
    assign timeout_flush = r_flush_pulse;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_pkt_framer
// Description : Directed self-checking bench for axis_pkt_framer. Instance
//               u_dut uses PKT_LEN=4/TIMEOUT=8; u_dut_nt uses PKT_LEN=4 with
//               the timeout disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_framer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic          timeout_flush;

    logic [DW-1:0] s1_tdata;
    logic          s1_tvalid;
    logic          s1_tready;
    logic [DW-1:0] m1_tdata;
    logic          m1_tvalid;
    logic          m1_tlast;
    logic          m1_tready;
    logic          flush1;

    always #5 clk = ~clk;

    axis_pkt_framer #(.DW(DW), .PKT_LEN(4), .TIMEOUT(8)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tlast       (m_tlast),
        .m_tready      (m_tready),
        .timeout_flush (timeout_flush)
    );

    axis_pkt_framer #(.DW(DW), .PKT_LEN(4), .TIMEOUT(0)) u_dut_nt (
        .clk           (clk),
        .rst           (rst),
        .s_tdata       (s1_tdata),
        .s_tvalid      (s1_tvalid),
        .s_tready      (s1_tready),
        .m_tdata       (m1_tdata),
        .m_tvalid      (m1_tvalid),
        .m_tlast       (m1_tlast),
        .m_tready      (m1_tready),
        .timeout_flush (flush1)
    );

    // Cycle counter and output monitor (handshake observed at the negedge
    // before the edge that completes it).
    int         cyc = 0;
    logic [8:0] got_b [512];
    int         got_c [512];
    int         ngot   = 0;
    int         nflush = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_tvalid && m_tready && ngot < 512) begin
            got_b[ngot] = {m_tlast, m_tdata};
            got_c[ngot] = cyc;
            ngot        = ngot + 1;
        end
        if (timeout_flush) nflush = nflush + 1;
    end

    int         vectors     = 0;
    int         miscompares = 0;
    logic [8:0] exp_b [16];
    int         nexp    = 0;
    int         acc_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        if (obs !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present one beat and wait (bounded) for it to be accepted. s_tvalid is
    // left high; the caller drives the next beat or deasserts it.
    task automatic send(input logic [DW-1:0] d);
        logic ok;
        bit   done;
        int   n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        done     = 1'b0;
        n        = 0;
        while (!done) begin
            @(negedge clk);
            ok = s_tready;
            step();
            if (ok) begin
                acc_cyc = cyc;
                done    = 1'b1;
            end else begin
                n = n + 1;
                if (n > 200) begin
                    check($sformatf("send_budget_%0h", d), 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic send1(input logic [DW-1:0] d);
        logic ok;
        bit   done;
        int   n;
        s1_tvalid = 1'b1;
        s1_tdata  = d;
        done      = 1'b0;
        n         = 0;
        while (!done) begin
            @(negedge clk);
            ok = s1_tready;
            step();
            if (ok) begin
                done = 1'b1;
            end else begin
                n = n + 1;
                if (n > 200) begin
                    check($sformatf("send1_budget_%0h", d), 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic pushexp(input logic [DW-1:0] d, input logic l);
        exp_b[nexp] = {l, d};
        nexp        = nexp + 1;
    endtask

    task automatic cmp_beats(input string tag, input int base);
        check({tag, "_count"}, 32'(ngot - base), 32'(nexp));
        for (int i = 0; i < nexp; i++) begin
            if (base + i < ngot)
                check($sformatf("%s_beat%0d", tag, i), 32'(got_b[base + i]), 32'(exp_b[i]));
        end
        nexp = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        int fbase;
        int acc13;
        int nv;
        int nf;

        rst       = 1'b1;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        m_tready  = 1'b1;
        s1_tvalid = 1'b0;
        s1_tdata  = '0;
        m1_tready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tdata", 32'(m_tdata), 32'd0);
        check("rst_m_tlast", 32'(m_tlast), 32'd0);
        check("rst_flush", 32'(timeout_flush), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_s_tready", 32'(s_tready), 32'd1);

        // T1: two full packets, no stall
        base  = ngot;
        fbase = nflush;
        for (int i = 1; i <= 8; i++) send(8'(i));
        s_tvalid = 1'b0;
        repeat (4) step();
        for (int i = 1; i <= 8; i++) pushexp(8'(i), (i == 4) || (i == 8));
        cmp_beats("t1", base);
        for (int i = 1; i < 8; i++)
            if (base + i < ngot)
                check($sformatf("t1_rate%0d", i), 32'(got_c[base + i] - got_c[base]), 32'(i));
        check("t1_flush", 32'(nflush - fbase), 32'd0);

        // T2: timeout close after 3 beats, then a full packet
        base  = ngot;
        fbase = nflush;
        send(8'h11);
        send(8'h12);
        send(8'h13);
        acc13    = acc_cyc;
        s_tvalid = 1'b0;
        repeat (12) step();
        pushexp(8'h11, 1'b0);
        pushexp(8'h12, 1'b0);
        pushexp(8'h13, 1'b1);
        cmp_beats("t2", base);
        if (base + 2 < ngot)
            check("t2_flush_delay", 32'(got_c[base + 2] - acc13), 32'd8);
        check("t2_flush_pulses", 32'(nflush - fbase), 32'd1);
        base = ngot;
        for (int i = 1; i <= 4; i++) send(8'(8'h20 + i));
        s_tvalid = 1'b0;
        repeat (4) step();
        for (int i = 1; i <= 4; i++) pushexp(8'(8'h20 + i), i == 4);
        cmp_beats("t2b", base);

        // T3: 10-cycle backpressure stall mid-packet
        base  = ngot;
        fbase = nflush;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(8'(i));
                s_tvalid = 1'b0;
            end
            begin
                repeat (3) step();
                m_tready = 1'b0;
                repeat (5) step();
                check("t3_s_tready_full", 32'(s_tready), 32'd0);
                check("t3_m_tvalid_held", 32'(m_tvalid), 32'd1);
                check("t3_m_tdata_held", 32'(m_tdata), 32'h02);
                repeat (5) step();
                m_tready = 1'b1;
            end
        join
        repeat (4) step();
        for (int i = 1; i <= 8; i++) pushexp(8'(i), (i == 4) || (i == 8));
        cmp_beats("t3", base);
        check("t3_flush", 32'(nflush - fbase), 32'd0);

        // T4: new beat arrives exactly in the would-be flush cycle
        base  = ngot;
        fbase = nflush;
        send(8'h41);
        send(8'h42);
        s_tvalid = 1'b0;
        repeat (7) step();
        send(8'h43);
        send(8'h44);
        s_tvalid = 1'b0;
        repeat (4) step();
        pushexp(8'h41, 1'b0);
        pushexp(8'h42, 1'b0);
        pushexp(8'h43, 1'b0);
        pushexp(8'h44, 1'b1);
        cmp_beats("t4", base);
        check("t4_flush", 32'(nflush - fbase), 32'd0);

        // T5: reset after 2 beats of a packet
        send(8'h51);
        send(8'h52);
        s_tvalid = 1'b0;
        rst      = 1'b1;
        #1;
        check("t5_s_tready_rst", 32'(s_tready), 32'd0);
        step();
        check("t5_m_tvalid_rst", 32'(m_tvalid), 32'd0);
        check("t5_s_tready_rst2", 32'(s_tready), 32'd0);
        rst = 1'b0;
        step();
        base = ngot;
        for (int i = 1; i <= 4; i++) send(8'(8'h60 + i));
        s_tvalid = 1'b0;
        repeat (12) step();
        for (int i = 1; i <= 4; i++) pushexp(8'(8'h60 + i), i == 4);
        cmp_beats("t5", base);

        // T6: timeout disabled, single beat held indefinitely
        send1(8'hA1);
        s1_tvalid = 1'b0;
        nv = 0;
        nf = 0;
        repeat (1000) begin
            step();
            if (m1_tvalid) nv = nv + 1;
            if (flush1) nf = nf + 1;
        end
        check("t6_no_output", 32'(nv), 32'd0);
        check("t6_no_flush", 32'(nf), 32'd0);
        send1(8'hA2);
        s1_tvalid = 1'b0;
        check("t6_m_tvalid", 32'(m1_tvalid), 32'd1);
        check("t6_m_tdata", 32'(m1_tdata), 32'hA1);
        check("t6_m_tlast", 32'(m1_tlast), 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
